video_sync_norm: RTL

VIDEO_SYNC_NORM -- requirements
Module: video_sync_norm

---
 rtl/video_sync_norm.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/video_sync_norm.sv
// Sync normaliser: registers blanked colour, measures H/V sync polarity from the
// high/low split of each period, emits active-low syncs and a timing-lock flag.
module video_sync_norm #(
  parameter int COLOR_DEPTH = 6,
  parameter int CNT_WIDTH   = 12
) (
  input  logic                   clk_sys,
  input  logic                   rst_n,
  input  logic                   ce_pix,
  input  logic [COLOR_DEPTH-1:0] R_in,
  input  logic [COLOR_DEPTH-1:0] G_in,
  input  logic [COLOR_DEPTH-1:0] B_in,
  input  logic                   HSync_in,
  input  logic                   VSync_in,
  input  logic                   HBlank,
  input  logic                   VBlank,
  output logic [COLOR_DEPTH-1:0] R,
  output logic [COLOR_DEPTH-1:0] G,
  output logic [COLOR_DEPTH-1:0] B,
  output logic                   HSync,
  output logic                   VSync,
  output logic                   pol_h,
  output logic                   pol_v,
  output logic                   locked
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  typedef enum logic [1:0] {UNLOCKED, CHECK, LOCKED} lock_state_t;

  lock_state_t          state, state_next;
  logic [1:0]           match_cnt, match_next;

  logic                 sync_seen, hs_prev, vs_prev;
  logic                 h_started, v_started;
  logic [CNT_WIDTH-1:0] h_hi, h_lo, h_len;
  logic [CNT_WIDTH-1:0] v_hi, v_lo;
  logic                 h_cand, v_cand;
  logic                 h_conf, v_conf;

  logic                 h_rise, v_rise, h_end, v_end, h_sat;
  logic [CNT_WIDTH:0]   h_sum;
  logic [CNT_WIDTH-1:0] h_len_new, v_hi_tot, v_lo_tot;
  logic                 h_cand_new, v_cand_new, h_agree, v_agree;
  logic                 pol_h_next, pol_v_next, h_mismatch, disrupt;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] val,
                                                   input logic en);
    if (en && (val != CNT_MAX)) return val + CNT_ONE;
    return val;
  endfunction

  // Period bookkeeping; the first edge after reset only opens measurement.
  always_comb begin
    h_rise     = sync_seen & HSync_in & ~hs_prev;
    v_rise     = sync_seen & VSync_in & ~vs_prev;
    h_end      = h_rise & h_started;
    v_end      = v_rise & v_started;
    h_sat      = (h_hi == CNT_MAX) | (h_lo == CNT_MAX);
    h_sum      = {1'b0, h_hi} + {1'b0, h_lo};
    h_len_new  = h_sum[CNT_WIDTH] ? CNT_MAX : h_sum[CNT_WIDTH-1:0];
    h_cand_new = (h_hi < h_lo);
    h_agree    = h_end & ~h_sat & (h_cand_new == h_cand);
    pol_h_next = h_agree ? h_cand_new : pol_h;
    h_mismatch = h_end & (h_sat | (h_len_new != h_len));
    // A line ending on the same sample as a V edge still belongs to the closing frame.
    v_hi_tot   = sat_inc(v_hi, h_end & vs_prev);
    v_lo_tot   = sat_inc(v_lo, h_end & ~vs_prev);
    v_cand_new = (v_hi_tot < v_lo_tot);
    v_agree    = v_end & (v_cand_new == v_cand);
    pol_v_next = v_agree ? v_cand_new : pol_v;
    disrupt    = h_sat | h_mismatch | (pol_h_next != pol_h) | (pol_v_next != pol_v);
  end

  always_comb begin
    state_next = state;
    match_next = match_cnt;
    if (ce_pix) begin
      case (state)
        UNLOCKED: begin
          match_next = 2'd0;
          if (!disrupt && h_conf && v_conf) state_next = CHECK;
        end
        CHECK: begin
          if (disrupt) begin
            state_next = UNLOCKED;
            match_next = 2'd0;
          end else if (h_end) begin
            if (match_cnt == 2'd3) begin
              state_next = LOCKED;
              match_next = 2'd0;
            end else begin
              match_next = match_cnt + 2'd1;
            end
          end
        end
        LOCKED: begin
          if (disrupt) state_next = UNLOCKED;
        end
        default: begin
          state_next = UNLOCKED;
          match_next = 2'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state     <= UNLOCKED;
      match_cnt <= 2'd0;
    end else begin
      state     <= state_next;
      match_cnt <= match_next;
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      R         <= '0;
      G         <= '0;
      B         <= '0;
      HSync     <= 1'b1;
      VSync     <= 1'b1;
      pol_h     <= 1'b0;
      pol_v     <= 1'b0;
      locked    <= 1'b0;
      sync_seen <= 1'b0;
      hs_prev   <= 1'b0;
      vs_prev   <= 1'b0;
      h_started <= 1'b0;
      v_started <= 1'b0;
      h_hi      <= '0;
      h_lo      <= '0;
      h_len     <= '0;
      v_hi      <= '0;
      v_lo      <= '0;
      h_cand    <= 1'b0;
      v_cand    <= 1'b0;
      h_conf    <= 1'b0;
      v_conf    <= 1'b0;
    end else if (ce_pix) begin
      R         <= (HBlank | VBlank) ? '0 : R_in;
      G         <= (HBlank | VBlank) ? '0 : G_in;
      B         <= (HBlank | VBlank) ? '0 : B_in;
      HSync     <= HSync_in ^ pol_h;
      VSync     <= VSync_in ^ pol_v;
      pol_h     <= pol_h_next;
      pol_v     <= pol_v_next;
      locked    <= (state_next == LOCKED);
      sync_seen <= 1'b1;
      hs_prev   <= HSync_in;
      vs_prev   <= VSync_in;

      if (h_rise) begin
        h_started <= 1'b1;
        h_hi      <= CNT_ONE;
        h_lo      <= '0;
      end else begin
        h_hi <= sat_inc(h_hi, HSync_in);
        h_lo <= sat_inc(h_lo, ~HSync_in);
      end
      if (h_end) begin
        h_len <= h_len_new;
        if (!h_sat) h_cand <= h_cand_new;
      end
      if (h_agree) h_conf <= 1'b1;

      if (v_rise) begin
        v_started <= 1'b1;
        v_hi      <= '0;
        v_lo      <= '0;
      end else begin
        v_hi <= v_hi_tot;
        v_lo <= v_lo_tot;
      end
      if (v_end) v_cand <= v_cand_new;
      if (v_agree) v_conf <= 1'b1;
    end
  end

endmodule
